// File: rtl/step_generator.sv
// Step/dir pulse generator for a microstepper driver with dir setup, halt and idle disable.
// Optional `STEPGEN_POSITION_EN adds a signed 32-bit step position counter.
module step_generator #(
  parameter int unsigned PULSE_WIDTH = 8,
  parameter int unsigned DIR_SETUP   = 4,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_steps,
  input  logic [23:0] cmd_period,
  input  logic        halt,
  output logic        step,
  output logic        dir,
  output logic        enable,
  output logic        busy,
  output logic [15:0] steps_remaining
`ifdef STEPGEN_POSITION_EN
  ,
  output logic signed [31:0] position
`endif
);

  localparam int unsigned SW   = 16;
  localparam int unsigned PERW = 24;
  localparam int unsigned IW   = 32;
  localparam logic [PERW-1:0] PW_M1      = PERW'(PULSE_WIDTH - 1);
  localparam logic [PERW-1:0] PW_LEN     = PERW'(PULSE_WIDTH);
  localparam logic [PERW-1:0] MIN_PERIOD = PERW'(PULSE_WIDTH + 1);
  localparam logic [PERW-1:0] SETUP_M1   = PERW'(DIR_SETUP - 1);
  localparam logic [IW-1:0]   HOLD_M1    = IW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE_HIGH, S_PULSE_LOW} state_t;

  state_t          r_state, w_state;
  logic [PERW-1:0] r_cnt, w_cnt;
  logic [PERW-1:0] r_low_len, w_low_len;
  logic            r_halt_req, w_halt_req;
  logic            r_setup_pend, w_setup_pend;
  logic            r_step, w_step;
  logic            r_dir, w_dir;
  logic            r_enable, w_enable;
  logic [SW-1:0]   r_steps_rem, w_steps_rem;
  logic [IW-1:0]   r_idle_cnt, w_idle_cnt;
  logic            w_enter_high;
  logic            w_accept;
  logic [PERW-1:0] w_eff_period;

  assign cmd_ready       = (r_state == S_IDLE) && !halt;
  assign busy            = (r_state != S_IDLE);
  assign w_accept        = cmd_valid && cmd_ready;
  assign w_eff_period    = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  assign step            = r_step;
  assign dir             = r_dir;
  assign enable          = r_enable;
  assign steps_remaining = r_steps_rem;

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_low_len    = r_low_len;
    w_halt_req   = r_halt_req;
    w_setup_pend = r_setup_pend;
    w_step       = r_step;
    w_dir        = r_dir;
    w_enable     = r_enable;
    w_steps_rem  = r_steps_rem;
    w_idle_cnt   = r_idle_cnt;
    w_enter_high = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_idle_cnt  = '0;
          w_enable    = 1'b0;
          w_halt_req  = 1'b0;
          w_steps_rem = cmd_steps;
          w_low_len   = w_eff_period - PW_LEN;
          if (cmd_steps == '0) begin
            // Zero-length move: spend one busy cycle, leave dir alone
            w_state = S_PULSE_LOW;
            w_cnt   = '0;
          end else if ((cmd_dir != r_dir) || r_enable || r_setup_pend) begin
            w_dir = cmd_dir;
            if (DIR_SETUP == 0) begin
              w_enter_high = 1'b1;
            end else begin
              w_state      = S_SETUP;
              w_cnt        = SETUP_M1;
              w_setup_pend = 1'b1;
            end
          end else begin
            w_enter_high = 1'b1;
          end
        end else begin
          if (r_idle_cnt != '1) w_idle_cnt = r_idle_cnt + IW'(1);
          if ((HOLD_CYCLES != 0) && (r_idle_cnt == HOLD_M1)) w_enable = 1'b1;
        end
      end
      S_SETUP: begin
        if (halt) begin
          w_state = S_IDLE;
        end else if (r_cnt == '0) begin
          w_setup_pend = 1'b0;
          w_enter_high = 1'b1;
        end else begin
          w_cnt = r_cnt - PERW'(1);
        end
      end
      S_PULSE_HIGH: begin
        if (halt) w_halt_req = 1'b1;
        if (r_cnt == '0) begin
          w_step = 1'b0;
          if (r_halt_req || halt) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_PULSE_LOW;
            w_cnt   = r_low_len - PERW'(1);
          end
        end else begin
          w_cnt = r_cnt - PERW'(1);
        end
      end
      S_PULSE_LOW: begin
        if (halt) begin
          w_state = S_IDLE;
        end else if (r_cnt == '0) begin
          if (r_steps_rem != '0) w_enter_high = 1'b1;
          else                   w_state      = S_IDLE;
        end else begin
          w_cnt = r_cnt - PERW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Every pulse starts here so rise-to-rise spacing is exactly the period
    if (w_enter_high) begin
      w_state     = S_PULSE_HIGH;
      w_step      = 1'b1;
      w_cnt       = PW_M1;
      w_steps_rem = w_steps_rem - SW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_low_len    <= '0;
      r_halt_req   <= 1'b0;
      r_setup_pend <= 1'b0;
      r_step       <= 1'b0;
      r_dir        <= 1'b0;
      r_enable     <= 1'b1;
      r_steps_rem  <= '0;
      r_idle_cnt   <= '0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_low_len    <= w_low_len;
      r_halt_req   <= w_halt_req;
      r_setup_pend <= w_setup_pend;
      r_step       <= w_step;
      r_dir        <= w_dir;
      r_enable     <= w_enable;
      r_steps_rem  <= w_steps_rem;
      r_idle_cnt   <= w_idle_cnt;
    end
  end

`ifdef STEPGEN_POSITION_EN
  logic signed [31:0] r_pos;
  assign position = r_pos;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           r_pos <= '0;
    else if (w_enter_high) r_pos <= r_pos + (w_dir ? 32'sd1 : -32'sd1);
  end
`endif

endmodule

// File: tb/tb_step_generator.sv
// Scoreboard bench for step_generator: issue tasks predict pulses and move ends, a monitor checks them.
module tb_step_generator;
  localparam int unsigned PW   = 8;
  localparam int unsigned DS   = 4;
  localparam int unsigned HOLD = 50;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [23:0] cmd_period = '0;
  logic        halt = 1'b0;
  logic        cmd_ready, step, dir, enable, busy;
  logic [15:0] steps_remaining;
`ifdef STEPGEN_POSITION_EN
  logic signed [31:0] position;
`endif

  step_generator #(.PULSE_WIDTH(PW), .DIR_SETUP(DS), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .halt(halt),
    .step(step), .dir(dir), .enable(enable), .busy(busy), .steps_remaining(steps_remaining)
`ifdef STEPGEN_POSITION_EN
    , .position(position)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int rise; bit d; int rem; } pulse_t;
  typedef struct { int x; int rem; } end_t;
  pulse_t pq[$];
  end_t   eq[$];

  // Reference model state
  bit m_dir = 1'b0;
  bit m_first = 1'b1;
  bit m_pend = 1'b0;
  int m_x = 0;
  bit mon_en = 1'b0;
  int pos_m = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a step rise or a move end
  logic p_step = 1'b0, p_busy = 1'b0, p_en = 1'b1, p_dir = 1'b0;
  int   hi_start = 0;
  int   dir_chg = -1000;
  always @(negedge clk) begin
    pulse_t pe;
    end_t   ee;
    if (mon_en) begin
      if (dir != p_dir) chk("dir_change_with_step_low", longint'(p_step | step), 0);
      if (step && !p_step) begin
        chk("dir_setup_before_rise", longint'((cyc - dir_chg) >= int'(DS)), 1);
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse at cycle %0d: got a step rise, expected none", cyc);
        end else begin
          pe = pq.pop_front();
          chk("rise_cycle", cyc, pe.rise);
          chk("rise_dir", dir, pe.d);
          chk("rise_steps_remaining", steps_remaining, pe.rem);
`ifdef STEPGEN_POSITION_EN
          chk("position", position, pos_m + (pe.d ? 1 : -1));
          pos_m <= pos_m + (pe.d ? 1 : -1);
`endif
        end
        hi_start <= cyc;
      end
      if (!step && p_step) chk("pulse_width", cyc - hi_start, PW);
      if (!busy && p_busy) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_move_end at cycle %0d: got busy fall, expected none", cyc);
        end else begin
          ee = eq.pop_front();
          chk("idle_entry_cycle", cyc, ee.x);
          chk("end_steps_remaining", steps_remaining, ee.rem);
        end
      end
      if (enable && !p_en) chk("enable_rise_cycle", cyc, m_x + int'(HOLD));
      if (dir != p_dir) dir_chg <= cyc;
    end
    p_step <= step;
    p_busy <= busy;
    p_en   <= enable;
    p_dir  <= dir;
  end

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout at cycle %0d: busy still 1, expected 0", cyc);
    end
  endtask

  // Called at a negedge with the DUT idle; halt_rel>0 pulses halt so it is sampled at edge accept+halt_rel
  task automatic issue(input bit d, input int steps, input int period, input int halt_rel);
    int a, eff, setup, n, h, xx, rl;
    bit en_prev;
    pulse_t pe;
    end_t   ee;
    a       = cyc + 1;
    en_prev = m_first ? 1'b1 : ((a - m_x) > int'(HOLD));
    chk("enable_before_accept", enable, en_prev);
    chk("cmd_ready_idle", cmd_ready, 1);
    eff   = (period < int'(PW) + 1) ? int'(PW) + 1 : period;
    setup = (steps > 0 && (d != m_dir || en_prev || m_pend)) ? int'(DS) : 0;
    h     = (halt_rel > 0) ? a + halt_rel : 32'h7fff_ffff;
    n     = 0;
    rl    = a;
    for (int k = 0; k < steps; k++) begin
      if (a + setup + k * eff < h) begin
        pe.rise = a + setup + k * eff;
        pe.d    = d;
        pe.rem  = steps - 1 - k;
        pq.push_back(pe);
        rl = pe.rise;
        n++;
      end
    end
    if (steps == 0)                                       xx = a + 1;
    else if (n > 0 && h > rl && h <= rl + int'(PW))       xx = rl + int'(PW);
    else if (n == steps && h >= rl + eff)                 xx = rl + eff;
    else                                                  xx = h;
    ee.x   = xx;
    ee.rem = steps - n;
    eq.push_back(ee);
    if (steps > 0) begin
      m_dir  = d;
      m_pend = (setup > 0 && n == 0);
    end
    m_first = 1'b0;
    m_x     = xx;

    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = 16'(steps);
    cmd_period = 24'(period);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("enable_after_accept", enable, 0);
    chk("dir_after_accept", dir, m_dir);
    chk("busy_after_accept", busy, 1);
    if (halt_rel > 0) begin
      while (cyc < h - 1) @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int steps, period, gap, eff, hr;
    bit d;
    repeat (3) @(negedge clk);
    chk("reset_step", step, 0);
    chk("reset_dir", dir, 0);
    chk("reset_enable", enable, 1);
    chk("reset_busy", busy, 0);
    chk("reset_steps_remaining", steps_remaining, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    halt = 1'b1;
    #1;
    chk("reset_cmd_ready_halt", cmd_ready, 0);
    halt = 1'b0;
`ifdef STEPGEN_POSITION_EN
    chk("reset_position", position, 0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    #1 mon_en = 1'b1;
    repeat (2) @(negedge clk);

    issue(1'b1, 3, 20, 0);
    issue(1'b1, 3, 5, 0);
    issue(1'b0, 0, 10, 0);
    issue(1'b1, 10, 20, 3 * 20 + 3);
    for (int i = 0; i < 200 && cyc < m_x + int'(HOLD) - 2; i++) @(negedge clk);
    issue(1'b1, 2, 12, 0);
    repeat (60) @(negedge clk);
    chk("enable_after_hold", enable, longint'((cyc - m_x) >= int'(HOLD)));

    for (int t = 0; t < 30; t++) begin
      gap    = int'($urandom_range(0, 70));
      d      = 1'($urandom_range(0, 1));
      steps  = int'($urandom_range(0, 5));
      period = int'($urandom_range(1, 30));
      eff    = (period < int'(PW) + 1) ? int'(PW) + 1 : period;
      hr     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DS + 2 + 32'(steps * eff))) : 0;
      repeat (gap) @(negedge clk);
      issue(d, steps, period, hr);
    end
    repeat (2) @(negedge clk);
    chk("pulse_queue_drained", pq.size(), 0);
    chk("end_queue_drained", eq.size(), 0);

    // Asynchronous reset in the middle of a pulse
    #1 mon_en = 1'b0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_dir    = ~dir;
    cmd_steps  = 16'd5;
    cmd_period = 24'd20;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && !step; i++) @(negedge clk);
    chk("step_high_before_reset", step, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_step", step, 0);
    chk("async_reset_enable", enable, 1);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_dir", dir, 0);
    chk("async_reset_steps_remaining", steps_remaining, 0);
`ifdef STEPGEN_POSITION_EN
    chk("async_reset_position", position, 0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
